// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // EXE operand select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX_MEM ALU result
    localparam logic [1:0] FWD_WB  = 2'b01;  // MEM_WB write-back value

    // Destination fields in the shadow entries are stored at this width.
    // Narrower register addresses are zero-extended, so AW must not exceed it.
    localparam int RD_MAX_W = 8;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                regwrite;
        logic                memtoreg;
    } stage_entry_t;

    localparam stage_entry_t STAGE_EMPTY = '0;

    // An entry can only feed a consumer if it really writes a non-x0 register.
    function automatic logic writes_reg(input stage_entry_t e);
        return e.valid && e.regwrite && (e.rd != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-operand comparator: qualifies one decode source register against the
// EX and MEM shadow entries and priority-encodes the forwarding select.
module hazard_fwd_cmp
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0]  rs_i,
    input  logic           rs_used_i,
    input  stage_entry_t   ex_e_i,
    input  stage_entry_t   mem_e_i,
    output logic           ex_match_o,
    output logic           mem_match_o,
    output logic [1:0]     sel_o
);

    logic [RD_MAX_W-1:0] rs_ext;
    logic                unused_mem_load;

    assign rs_ext          = RD_MAX_W'(rs_i);
    assign unused_mem_load = mem_e_i.memtoreg;

    // Qualified matches and select; the youngest producer (EX) wins, and a
    // load in EX never forwards because its data does not exist yet.
    always_comb begin
        ex_match_o  = rs_used_i && writes_reg(ex_e_i)  && (ex_e_i.rd  == rs_ext);
        mem_match_o = rs_used_i && writes_reg(mem_e_i) && (mem_e_i.rd == rs_ext);
        sel_o       = FWD_RF;
        if (ex_match_o && !ex_e_i.memtoreg) begin
            sel_o = FWD_MEM;
        end else if (mem_match_o) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB tracker, load-use stall FSM,
// decode-resolved branch flush, registered forwarding selects and saturating
// stall/flush event counters.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal issue; a load-use hazard stalls this cycle and, for
//       | multi-cycle loads, moves to WAIT
// WAIT  | remaining load-latency bubbles; hazards are not evaluated here
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             global_reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_regwrite,
    input  logic             id_memtoreg,
    input  logic             branch_taken,
    output logic             stall,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] WAIT_INIT = 2'(LOAD_LAT - 1);

    hz_state_e    state_q;
    logic [1:0]   wait_cnt_q;

    stage_entry_t ex_q, mem_q, wb_q;
    stage_entry_t ex_d;
    stage_entry_t id_entry;

    logic [1:0]   fwd_a_q, fwd_b_q;
    logic [1:0]   fwd_a_d, fwd_b_d;
    logic [1:0]   sel_a, sel_b;
    logic         a_ex_match, b_ex_match;
    logic         a_mem_match, b_mem_match;
    logic         load_use;

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d;

    logic         unused_sig;

    hazard_fwd_cmp #(.AW(AW)) u_cmp_a (
        .rs_i        (id_rs1),
        .rs_used_i   (id_rs1_used),
        .ex_e_i      (ex_q),
        .mem_e_i     (mem_q),
        .ex_match_o  (a_ex_match),
        .mem_match_o (a_mem_match),
        .sel_o       (sel_a)
    );

    hazard_fwd_cmp #(.AW(AW)) u_cmp_b (
        .rs_i        (id_rs2),
        .rs_used_i   (id_rs2_used),
        .ex_e_i      (ex_q),
        .mem_e_i     (mem_q),
        .ex_match_o  (b_ex_match),
        .mem_match_o (b_mem_match),
        .sel_o       (sel_b)
    );

    // WB is kept for completeness of the shadow pipeline; MEM-stage matches
    // only matter through the encoded selects.
    assign unused_sig = ^{wb_q, a_mem_match, b_mem_match};

    assign load_use = id_valid && ex_q.memtoreg && (a_ex_match || b_ex_match);

    // Mealy pipeline controls; a stall masks the branch so decode re-presents it.
    always_comb begin
        stall       = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        if (state_q == WAIT || load_use) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
        end else if (branch_taken) begin
            flush_if_id = 1'b1;
        end
    end

    // Stall sequencing: RUN covers the first bubble, WAIT the remaining LOAD_LAT-1.
    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        wait_cnt_q <= WAIT_INIT;
                        if (LOAD_LAT > 1) begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_q <= 2'd1) begin
                        wait_cnt_q <= '0;
                        state_q    <= RUN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    // Decode fields packed as a tracker entry; a bubble enters EX as all zero.
    always_comb begin
        id_entry          = STAGE_EMPTY;
        id_entry.valid    = 1'b1;
        id_entry.rd       = RD_MAX_W'(id_rd);
        id_entry.regwrite = id_regwrite;
        id_entry.memtoreg = id_memtoreg;
        ex_d              = (id_valid && !bubble_ex) ? id_entry : STAGE_EMPTY;
    end

    // Shadow EX/MEM/WB tracker advancing every edge.
    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            ex_q  <= STAGE_EMPTY;
            mem_q <= STAGE_EMPTY;
            wb_q  <= STAGE_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Selects computed in decode; a stalled cycle sends a bubble, so select RF.
    always_comb begin
        fwd_a_d = stall ? FWD_RF : sel_a;
        fwd_b_d = stall ? FWD_RF : sel_b;
    end

    // Forwarding select registers, valid while the instruction sits in EX.
    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

    // Saturating event counters: hold at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_if_id && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share the decode stimulus:
// u_dut_a (LOAD_LAT=1, 16-bit counters) and u_dut_b (LOAD_LAT=3, 4-bit
// counters). Each scenario starts from reset and checks the relevant instance.
module tb_hazard_ctrl;

    logic       clk;
    logic       global_reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used;
    logic       id_regwrite, id_memtoreg;
    logic       branch_taken;

    logic        stall_a, bubble_a, flush_a;
    logic [1:0]  fwd_a_a, fwd_b_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;

    logic        stall_b, bubble_b, flush_b;
    logic [1:0]  fwd_a_b, fwd_b_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    int n_chk  = 0;
    int n_pass = 0;

    hazard_ctrl #(.AW(5), .LOAD_LAT(1), .CNT_W(16)) u_dut_a (
        .clk          (clk),
        .global_reset (global_reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memtoreg  (id_memtoreg),
        .branch_taken (branch_taken),
        .stall        (stall_a),
        .bubble_ex    (bubble_a),
        .flush_if_id  (flush_a),
        .fwd_a        (fwd_a_a),
        .fwd_b        (fwd_b_a),
        .stall_cnt    (stall_cnt_a),
        .flush_cnt    (flush_cnt_a)
    );

    hazard_ctrl #(.AW(5), .LOAD_LAT(3), .CNT_W(4)) u_dut_b (
        .clk          (clk),
        .global_reset (global_reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memtoreg  (id_memtoreg),
        .branch_taken (branch_taken),
        .stall        (stall_b),
        .bubble_ex    (bubble_b),
        .flush_if_id  (flush_b),
        .fwd_a        (fwd_a_b),
        .fwd_b        (fwd_b_b),
        .stall_cnt    (stall_cnt_b),
        .flush_cnt    (flush_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic m2r);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memtoreg = m2r;
    endtask

    task automatic id_nop();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // lw x5, 0(x1)
    task automatic id_lw_x5();
        id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    endtask

    // add x6, x5, x7
    task automatic id_add_x5();
        id_set(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        id_nop();
        branch_taken = 1'b0;
        global_reset = 1'b0;
        tick();
        tick();
        global_reset = 1'b1;
    endtask

    initial begin
        id_nop();
        branch_taken = 1'b0;
        global_reset = 1'b0;

        // Reset values
        tick();
        chk("rst_stall_a", 32'(stall_a), 32'd0);
        chk("rst_bubble_b", 32'(bubble_b), 32'd0);
        chk("rst_fwd_a", 32'({fwd_a_a, fwd_b_a}), 32'd0);
        chk("rst_cnt_a", 32'({stall_cnt_a, flush_cnt_a}), 32'd0);
        global_reset = 1'b1;

        // Load-use with LOAD_LAT=1
        do_reset();
        id_lw_x5();
        #2 chk("lu1_no_stall_on_lw", 32'(stall_a), 32'd0);
        tick();
        id_add_x5();
        #2 chk("lu1_stall", 32'(stall_a), 32'd1);
        chk("lu1_bubble", 32'(bubble_a), 32'd1);
        tick();
        chk("lu1_fwd_in_bubble", 32'(fwd_a_a), 32'b00);
        #2 chk("lu1_stall_released", 32'(stall_a), 32'd0);
        tick();
        id_nop();
        chk("lu1_fwd_a_wb", 32'(fwd_a_a), 32'b01);
        chk("lu1_fwd_b_rf", 32'(fwd_b_a), 32'b00);
        chk("lu1_stall_cnt", 32'(stall_cnt_a), 32'd1);

        // Load-use with LOAD_LAT=3
        do_reset();
        id_lw_x5();
        tick();
        id_add_x5();
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("lu3_stall_%0d", i), 32'({stall_b, bubble_b}), 32'b11);
            tick();
            chk($sformatf("lu3_fwd_bubble_%0d", i), 32'(fwd_a_b), 32'b00);
        end
        #2 chk("lu3_stall_done", 32'(stall_b), 32'd0);
        tick();
        id_nop();
        chk("lu3_fwd_after", 32'(fwd_a_b), 32'b00);
        chk("lu3_stall_cnt", 32'(stall_cnt_b), 32'd3);

        // ALU forwarding: EX beats MEM
        do_reset();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        #2 chk("prio_no_stall", 32'(stall_a), 32'd0);
        tick();
        id_nop();
        chk("prio_fwd_a", 32'(fwd_a_a), 32'b10);
        chk("prio_fwd_b", 32'(fwd_b_a), 32'b10);

        // rd = x0 never forwards
        do_reset();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        tick();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        id_nop();
        chk("x0_fwd", 32'({fwd_a_a, fwd_b_a}), 32'd0);

        // Operands matching different stages resolve independently
        do_reset();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        id_nop();
        chk("split_fwd_a", 32'(fwd_a_a), 32'b01);
        chk("split_fwd_b", 32'(fwd_b_a), 32'b10);

        // Unused source never forwards
        do_reset();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd3, 1'b0, 5'd3, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        id_nop();
        chk("unused_src_fwd", 32'({fwd_a_a, fwd_b_a}), 32'd0);

        // Branch flush, then branch colliding with a load-use stall
        do_reset();
        branch_taken = 1'b1;
        #2 chk("br_flush", 32'(flush_a), 32'd1);
        tick();
        branch_taken = 1'b0;
        chk("br_flush_cnt", 32'(flush_cnt_a), 32'd1);
        #2 chk("br_flush_drop", 32'(flush_a), 32'd0);
        id_lw_x5();
        tick();
        id_add_x5();
        branch_taken = 1'b1;
        #2 chk("col_stall", 32'(stall_a), 32'd1);
        chk("col_no_flush", 32'(flush_a), 32'd0);
        tick();
        branch_taken = 1'b0;
        id_nop();
        chk("col_flush_cnt", 32'(flush_cnt_a), 32'd1);
        chk("col_stall_cnt", 32'(stall_cnt_a), 32'd1);

        // Reset in the middle of a LOAD_LAT=3 stall
        do_reset();
        id_lw_x5();
        tick();
        id_add_x5();
        tick();
        #2 chk("mid_wait_stall", 32'(stall_b), 32'd1);
        global_reset = 1'b0;
        #1;
        chk("mid_rst_stall", 32'({stall_b, bubble_b, flush_b}), 32'd0);
        chk("mid_rst_fwd", 32'({fwd_a_b, fwd_b_b}), 32'd0);
        chk("mid_rst_cnt", 32'(stall_cnt_b), 32'd0);
        @(negedge clk);
        global_reset = 1'b1;
        #1 chk("post_rst_stall0", 32'(stall_b), 32'd0);
        tick();
        #2 chk("post_rst_stall1", 32'(stall_b), 32'd0);
        tick();
        id_nop();
        chk("post_rst_cnt", 32'(stall_cnt_b), 32'd0);

        // Counter saturation: 7 hazards x 3 stall cycles on the 4-bit counter
        do_reset();
        for (int k = 0; k < 7; k++) begin
            id_lw_x5();
            tick();
            id_add_x5();
            repeat (4) tick();
            if (k == 3) begin
                chk("sat_cnt_12", 32'(stall_cnt_b), 32'd12);
            end
        end
        id_nop();
        tick();
        chk("sat_cnt_b", 32'(stall_cnt_b), 32'd15);
        chk("sat_cnt_a", 32'(stall_cnt_a), 32'd7);
        chk("sat_flush_b", 32'(flush_cnt_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
